counter_client_afu: RTL

- Load-generating client that sits directly upstream of two counter servers. It drives increment traffic into both servers, then reads each server back and checks the final count.
- Launched by the CSR start level and reports completion through done. The top level ANDs done across client instances to form finish.
- Runs a fixed per-run sequence: issue, drain, readback, done.

---
 rtl/counter_client_afu.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/counter_client_afu.sv
// Load-generating client for two counter servers: issues INC traffic on both lanes,
// drains the acks, reads each server back and checks the final count.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | outputs quiet, waiting for a rising edge on start
//   ISSUE     | INCs flow on each lane, window-limited by outstanding acks
//   DRAIN     | all INCs sent, waiting for the remaining acks
//   READBACK  | one READ per lane, each lane drops valid after its handshake
//   WAIT_RD   | waiting for one READ response per lane, checking the data
//   DONE      | done high, cycles frozen, waiting for start to fall
module counter_client_afu #(
   parameter int MAX_OUTSTANDING = 8,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] count_to,
   output logic             done,
   output logic             error,
   output logic [31:0]      cycles,
   output logic             s0_req_valid,
   input  logic             s0_req_ready,
   output logic [1:0]       s0_req_op,
   input  logic             s0_resp_valid,
   input  logic [63:0]      s0_resp_data,
   output logic             s1_req_valid,
   input  logic             s1_req_ready,
   output logic [1:0]       s1_req_op,
   input  logic             s1_resp_valid,
   input  logic [63:0]      s1_resp_data
);

   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_RD   = 2'b10;
   localparam logic [7:0] OUT_MAX = 8'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_DRAIN, S_READBACK, S_WAIT_RD, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             start_q;
   logic [CNT_W-1:0] cnt_lat_q, cnt_lat_d;
   logic             error_q, error_d;
   logic [31:0]      cycles_q, cycles_d;
   logic [1:0]       rd_hs_q, rd_hs_d;
   logic [1:0]       rd_rsp_q, rd_rsp_d;
   logic [CNT_W-1:0] sent_q [2];
   logic [CNT_W-1:0] sent_d [2];
   logic [CNT_W-1:0] acked_q [2];
   logic [CNT_W-1:0] acked_d [2];
   logic [7:0]       outst_q [2];
   logic [7:0]       outst_d [2];

   logic [1:0]       req_valid, req_ready, resp_valid, hs;
   logic [1:0]       req_op [2];
   logic [63:0]      resp_data [2];
   logic [63:0]      exp_data;
   logic             launch;

   assign req_ready    = {s1_req_ready, s0_req_ready};
   assign resp_valid   = {s1_resp_valid, s0_resp_valid};
   assign resp_data[0] = s0_resp_data;
   assign resp_data[1] = s1_resp_data;
   assign s0_req_valid = req_valid[0];
   assign s0_req_op    = req_op[0];
   assign s1_req_valid = req_valid[1];
   assign s1_req_op    = req_op[1];

   assign launch   = (state_q == S_IDLE) && start && !start_q;
   assign exp_data = {{(64-CNT_W){1'b0}}, cnt_lat_q};
   assign hs       = req_valid & req_ready;

   assign done   = (state_q == S_DONE);
   assign error  = error_q;
   assign cycles = cycles_q;

   // Request valid is a pure function of registered state, so once raised it
   // cannot drop before the handshake: outstanding only shrinks while waiting.
   always_comb begin
      req_valid = '0;
      for (int n = 0; n < 2; n++) begin
         req_op[n] = 2'b00;
         if (state_q == S_ISSUE && sent_q[n] < cnt_lat_q && outst_q[n] < OUT_MAX) begin
            req_valid[n] = 1'b1;
            req_op[n]    = OP_INC;
         end else if (state_q == S_READBACK && !rd_hs_q[n]) begin
            req_valid[n] = 1'b1;
            req_op[n]    = OP_RD;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_lat_d = cnt_lat_q;
      error_d   = error_q;
      cycles_d  = cycles_q;
      rd_hs_d   = rd_hs_q;
      rd_rsp_d  = rd_rsp_q;
      for (int n = 0; n < 2; n++) begin
         sent_d[n]  = sent_q[n];
         acked_d[n] = acked_q[n];
         outst_d[n] = outst_q[n];
      end

      if ((state_q == S_ISSUE || state_q == S_DRAIN || state_q == S_READBACK ||
           state_q == S_WAIT_RD) && cycles_q != '1) begin
         cycles_d = cycles_q + 32'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (|resp_valid) error_d = 1'b1;
            if (launch) begin
               cnt_lat_d = count_to;
               error_d   = 1'b0;
               cycles_d  = '0;
               rd_hs_d   = '0;
               rd_rsp_d  = '0;
               for (int n = 0; n < 2; n++) begin
                  sent_d[n]  = '0;
                  acked_d[n] = '0;
                  outst_d[n] = '0;
               end
               state_d = (count_to == '0) ? S_READBACK : S_ISSUE;
            end
         end

         S_ISSUE, S_DRAIN: begin
            for (int n = 0; n < 2; n++) begin
               // An ack with nothing outstanding is flagged and otherwise dropped.
               if (resp_valid[n] && outst_q[n] == 8'd0) begin
                  error_d    = 1'b1;
                  outst_d[n] = outst_q[n] + 8'(hs[n]);
               end else begin
                  outst_d[n] = outst_q[n] + 8'(hs[n]) - 8'(resp_valid[n]);
                  acked_d[n] = acked_q[n] + CNT_W'(resp_valid[n]);
               end
               sent_d[n] = sent_q[n] + CNT_W'(hs[n]);
            end
            if (state_q == S_ISSUE && sent_q[0] == cnt_lat_q && sent_q[1] == cnt_lat_q)
               state_d = S_DRAIN;
            if (state_q == S_DRAIN && outst_q[0] == 8'd0 && outst_q[1] == 8'd0)
               state_d = S_READBACK;
         end

         S_READBACK: begin
            if (|resp_valid) error_d = 1'b1;
            rd_hs_d = rd_hs_q | hs;
            if (&rd_hs_d) state_d = S_WAIT_RD;
         end

         S_WAIT_RD: begin
            for (int n = 0; n < 2; n++) begin
               if (resp_valid[n] && (rd_rsp_q[n] || resp_data[n] != exp_data))
                  error_d = 1'b1;
            end
            rd_rsp_d = rd_rsp_q | resp_valid;
            if (&rd_rsp_d) state_d = S_DONE;
         end

         S_DONE: begin
            if (|resp_valid) error_d = 1'b1;
            if (!start) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // start_q resets high so a start level held through reset cannot launch a run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         start_q   <= 1'b1;
         cnt_lat_q <= '0;
         error_q   <= 1'b0;
         cycles_q  <= '0;
         rd_hs_q   <= '0;
         rd_rsp_q  <= '0;
         for (int n = 0; n < 2; n++) begin
            sent_q[n]  <= '0;
            acked_q[n] <= '0;
            outst_q[n] <= '0;
         end
      end else begin
         state_q   <= state_d;
         start_q   <= start;
         cnt_lat_q <= cnt_lat_d;
         error_q   <= error_d;
         cycles_q  <= cycles_d;
         rd_hs_q   <= rd_hs_d;
         rd_rsp_q  <= rd_rsp_d;
         for (int n = 0; n < 2; n++) begin
            sent_q[n]  <= sent_d[n];
            acked_q[n] <= acked_d[n];
            outst_q[n] <= outst_d[n];
         end
      end
   end

endmodule
